// File: rtl/rom_rd_arbiter_if.sv
// rom_rd_arbiter_if: bundle of the two requester channels and the ROM port of rom_rd_arbiter.
//   req0_*/rsp0_* : port 0 request (vld/addr/rdy) and response (vld/data/rdy)
//   req1_*/rsp1_* : port 1 request and response, same shape as port 0
//   rom_*         : ROM enable/address out of the arbiter, read data back in
// Modports: slave = the arbiter itself, master = requesters plus the ROM.
interface rom_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              req0_vld;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_rdy;
  logic              rsp0_vld;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_rdy;

  logic              req1_vld;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_rdy;
  logic              rsp1_vld;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_rdy;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  req0_vld, req0_addr, rsp0_rdy,
    input  req1_vld, req1_addr, rsp1_rdy,
    input  rom_data,
    output req0_rdy, rsp0_vld, rsp0_data,
    output req1_rdy, rsp1_vld, rsp1_data,
    output rom_en, rom_addr
  );

  modport master (
    output req0_vld, req0_addr, rsp0_rdy,
    output req1_vld, req1_addr, rsp1_rdy,
    output rom_data,
    input  req0_rdy, rsp0_vld, rsp0_data,
    input  req1_rdy, rsp1_vld, rsp1_data,
    input  rom_en, rom_addr
  );
endinterface

// File: rtl/rom_rd_arbiter.sv
// rom_rd_arbiter: two-port round-robin arbiter in front of a single combinational-read ROM.
// One read is in flight at a time: IDLE (grant) -> READ (ROM enabled one cycle, data captured)
// -> RESP (response held until the winner consumes it).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous reset, active low
//   bus     : rom_rd_arbiter_if.slave, request/response channels for ports 0/1 and the ROM port
module rom_rd_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rom_rd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

  state_e            state_q;
  logic              rr_q;       // port favoured when both request
  logic              win_q;      // port owning the in-flight read
  logic [ADDR_W-1:0] addr_q;     // doubles as the ROM address output
  logic              rom_en_q;
  logic              rsp0_vld_q;
  logic              rsp1_vld_q;
  logic [DATA_W-1:0] rsp0_data_q;
  logic [DATA_W-1:0] rsp1_data_q;

  logic gnt0;
  logic gnt1;
  logic rsp_take;

  // Grant is combinational so a request is acknowledged in the cycle it is seen in IDLE.
  // Qualified with i_rst_n so ready is forced low while reset is held.
  assign gnt0 = i_rst_n && (state_q == StIdle) && bus.req0_vld && (!bus.req1_vld || !rr_q);
  assign gnt1 = i_rst_n && (state_q == StIdle) && bus.req1_vld && (!bus.req0_vld || rr_q);

  assign rsp_take = win_q ? bus.rsp1_rdy : bus.rsp0_rdy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      win_q       <= 1'b0;
      addr_q      <= '0;
      rom_en_q    <= 1'b0;
      rsp0_vld_q  <= 1'b0;
      rsp1_vld_q  <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt0 || gnt1) begin
            addr_q   <= gnt1 ? bus.req1_addr : bus.req0_addr;
            win_q    <= gnt1;
            rom_en_q <= 1'b1;
            state_q  <= StRead;
          end
        end
        StRead: begin
          rom_en_q <= 1'b0;
          if (win_q) begin
            rsp1_data_q <= bus.rom_data;
            rsp1_vld_q  <= 1'b1;
          end else begin
            rsp0_data_q <= bus.rom_data;
            rsp0_vld_q  <= 1'b1;
          end
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_take) begin
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            rr_q       <= ~win_q;  // the loser gets priority next time
            state_q    <= StIdle;
          end
        end
        default: begin
          rom_en_q <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign bus.req0_rdy  = gnt0;
  assign bus.req1_rdy  = gnt1;
  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = addr_q;
  assign bus.rsp0_vld  = rsp0_vld_q;
  assign bus.rsp1_vld  = rsp1_vld_q;
  assign bus.rsp0_data = rsp0_data_q;
  assign bus.rsp1_data = rsp1_data_q;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// tb_rom_rd_arbiter: cycle-by-cycle directed vectors for rom_rd_arbiter.
// Each vector holds the inputs for one clock cycle and the outputs expected during that cycle.
// ROM model: data = addr*17 while enabled, 0xA5 otherwise.
module tb_rom_rd_arbiter;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef struct {
    bit          rst_n;
    bit          v0;
    bit [AW-1:0] a0;
    bit          v1;
    bit [AW-1:0] a1;
    bit          r0;
    bit          r1;
  } in_t;

  typedef struct packed {
    logic          rdy0;
    logic          rdy1;
    logic          en;
    logic [AW-1:0] ra;
    logic          sv0;
    logic [DW-1:0] sd0;
    logic          sv1;
    logic [DW-1:0] sd1;
  } out_t;

  typedef struct {
    string name;
    in_t   vi;
    out_t  vo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  rom_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_data = bus.rom_en ? DW'(bus.rom_addr) * DW'(17) : DW'(8'hA5);

  function automatic vec_t mk(input string name, input bit rs, input bit v0, input int a0,
                              input bit v1, input int a1, input bit r0, input bit r1,
                              input bit rdy0, input bit rdy1, input bit en, input int ra,
                              input bit sv0, input int sd0, input bit sv1, input int sd1);
    vec_t v;
    v.name     = name;
    v.vi.rst_n = rs;
    v.vi.v0    = v0;
    v.vi.a0    = AW'(a0);
    v.vi.v1    = v1;
    v.vi.a1    = AW'(a1);
    v.vi.r0    = r0;
    v.vi.r1    = r1;
    v.vo.rdy0  = rdy0;
    v.vo.rdy1  = rdy1;
    v.vo.en    = en;
    v.vo.ra    = AW'(ra);
    v.vo.sv0   = sv0;
    v.vo.sd0   = DW'(sd0);
    v.vo.sv1   = sv1;
    v.vo.sd1   = DW'(sd1);
    return v;
  endfunction

  // Drive one cycle's inputs after the falling edge, then check outputs before the rising edge.
  task automatic cyc(input vec_t v);
    out_t act;
    @(negedge clk);
    rst_n         = v.vi.rst_n;
    bus.req0_vld  = v.vi.v0;
    bus.req0_addr = v.vi.a0;
    bus.req1_vld  = v.vi.v1;
    bus.req1_addr = v.vi.a1;
    bus.rsp0_rdy  = v.vi.r0;
    bus.rsp1_rdy  = v.vi.r1;
    #1;
    act = '{rdy0: bus.req0_rdy, rdy1: bus.req1_rdy, en: bus.rom_en, ra: bus.rom_addr,
            sv0: bus.rsp0_vld, sd0: bus.rsp0_data, sv1: bus.rsp1_vld, sd1: bus.rsp1_data};
    n_cmp++;
    if (act !== v.vo) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b%b en=%b addr=%h v0=%b d0=%h v1=%b d1=%h, want rdy=%b%b en=%b addr=%h v0=%b d0=%h v1=%b d1=%h",
               v.name, act.rdy0, act.rdy1, act.en, act.ra, act.sv0, act.sd0, act.sv1, act.sd1,
               v.vo.rdy0, v.vo.rdy1, v.vo.en, v.vo.ra, v.vo.sv0, v.vo.sd0, v.vo.sv1, v.vo.sd1);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req0_vld  = 1'b0;
    bus.req0_addr = '0;
    bus.req1_vld  = 1'b0;
    bus.req1_addr = '0;
    bus.rsp0_rdy  = 1'b0;
    bus.rsp1_rdy  = 1'b0;

    //                    rst v0 a0 v1 a1 r0 r1   rdy0 rdy1 en ra sv0 sd0  sv1 sd1
    vecs.push_back(mk("rst_hold",     0, 1, 3, 1, 5, 0, 0,  0, 0, 0, 0, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("rst_hold2",    0, 1, 3, 1, 5, 0, 0,  0, 0, 0, 0, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("single_acc",   1, 1, 3, 0, 0, 1, 0,  1, 0, 0, 0, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("single_read",  1, 0, 0, 0, 0, 1, 0,  0, 0, 1, 3, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("single_rsp",   1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 3, 1, 'h33, 0, 'h00));
    vecs.push_back(mk("single_idle",  1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 'h33, 0, 'h00));
    vecs.push_back(mk("late_acc",     1, 1, 4, 0, 0, 0, 0,  1, 0, 0, 3, 0, 'h33, 0, 'h00));
    vecs.push_back(mk("late_read",    1, 0, 9, 0, 0, 0, 0,  0, 0, 1, 4, 0, 'h33, 0, 'h00));
    vecs.push_back(mk("late_rsp_hold",1, 0, 9, 0, 0, 0, 0,  0, 0, 0, 4, 1, 'h44, 0, 'h00));
    vecs.push_back(mk("late_rsp_take",1, 0, 9, 0, 0, 1, 0,  0, 0, 0, 4, 1, 'h44, 0, 'h00));
    vecs.push_back(mk("late_idle",    1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, 0, 'h44, 0, 'h00));
    vecs.push_back(mk("mid_acc",      1, 0, 0, 1, 7, 0, 0,  0, 1, 0, 4, 0, 'h44, 0, 'h00));
    vecs.push_back(mk("mid_read",     1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 7, 0, 'h44, 0, 'h00));
    vecs.push_back(mk("mid_rst",      0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("mid_post",     1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("mid_post2",    1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("both_acc0",    1, 1, 1, 1, 2, 1, 1,  1, 0, 0, 0, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("both_read0",   1, 1, 1, 1, 2, 1, 1,  0, 0, 1, 1, 0, 'h00, 0, 'h00));
    vecs.push_back(mk("both_rsp0",    1, 1, 1, 1, 2, 1, 1,  0, 0, 0, 1, 1, 'h11, 0, 'h00));
    vecs.push_back(mk("both_acc1",    1, 1, 1, 1, 2, 1, 1,  0, 1, 0, 1, 0, 'h11, 0, 'h00));
    vecs.push_back(mk("both_read1",   1, 1, 1, 1, 2, 1, 1,  0, 0, 1, 2, 0, 'h11, 0, 'h00));
    vecs.push_back(mk("both_rsp1",    1, 1, 1, 1, 2, 1, 1,  0, 0, 0, 2, 0, 'h11, 1, 'h22));
    vecs.push_back(mk("both_acc0b",   1, 1, 1, 1, 2, 1, 1,  1, 0, 0, 2, 0, 'h11, 0, 'h22));
    vecs.push_back(mk("both_read0b",  1, 0, 0, 0, 0, 1, 1,  0, 0, 1, 1, 0, 'h11, 0, 'h22));
    vecs.push_back(mk("both_rsp0b",   1, 0, 0, 0, 0, 1, 1,  0, 0, 0, 1, 1, 'h11, 0, 'h22));
    vecs.push_back(mk("both_idle",    1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 'h11, 0, 'h22));

    for (int i = 0; i < vecs.size(); i++) cyc(vecs[i]);

    // Response stall: port1 reads addr 15 and holds the response for 10 cycles while port0 waits.
    cyc(mk("stall_acc1",  1, 0, 0, 1, 15, 0, 0,  0, 1, 0, 1, 0, 'h11, 0, 'h22));
    cyc(mk("stall_read1", 1, 0, 0, 0, 0,  0, 0,  0, 0, 1, 15, 0, 'h11, 0, 'h22));
    for (int i = 0; i < 10; i++) begin
      cyc(mk($sformatf("stall_hold%0d", i), 1, 1, 6, 0, 0, 0, 0,
             0, 0, 0, 15, 0, 'h11, 1, 'hFF));
    end
    cyc(mk("stall_take",  1, 1, 6, 0, 0, 0, 1,  0, 0, 0, 15, 0, 'h11, 1, 'hFF));
    cyc(mk("stall_acc0",  1, 1, 6, 0, 0, 0, 0,  1, 0, 0, 15, 0, 'h11, 0, 'hFF));
    cyc(mk("stall_read0", 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 6, 0, 'h11, 0, 'hFF));
    cyc(mk("stall_rsp0",  1, 0, 0, 0, 0, 1, 0,  0, 0, 0, 6, 1, 'h66, 0, 'hFF));

    // Address sweep: port0 reads every address back-to-back, one result per 3 cycles.
    begin
      int prev_a = 6;
      int prev_d = 'h66;
      for (int k = 0; k < 16; k++) begin
        cyc(mk($sformatf("sweep_acc%0d", k),  1, 1, k, 0, 0, 1, 0,
               1, 0, 0, prev_a, 0, prev_d, 0, 'hFF));
        cyc(mk($sformatf("sweep_read%0d", k), 1, 1, k, 0, 0, 1, 0,
               0, 0, 1, k, 0, prev_d, 0, 'hFF));
        cyc(mk($sformatf("sweep_rsp%0d", k),  1, 1, k, 0, 0, 1, 0,
               0, 0, 0, k, 1, k * 17, 0, 'hFF));
        prev_a = k;
        prev_d = k * 17;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
